// File: rtl/hazard_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_pkg
//
// Purpose : Shared constants for the issue-side register scoreboard and for
//           the decoder that feeds it. Keeping the register encoding and the
//           per-class result latencies in one place means decode and the
//           scoreboard can never disagree about how long a result takes to
//           become forwardable.
//
// Contents: NREG / AW / LW / NULL_REG geometry, LAT_* latency constants,
//           the operation-class enum and a helper mapping class -> latency.
// ---------------------------------------------------------------------------
package hazard_scoreboard_pkg;

  // Architectural register file geometry.
  localparam int NREG     = 32;
  localparam int AW       = 5;
  localparam int LW       = 3;

  // Register 31 encodes "no register" and is never tracked.
  localparam int NULL_REG = 31;

  // Width of the saturating stall performance counter.
  localparam int SC_W     = 16;

  // Extra cycles before a result can be forwarded to a dependent instruction.
  localparam logic [LW-1:0] LAT_ALU  = 3'd0;
  localparam logic [LW-1:0] LAT_LOAD = 3'd1;
  localparam logic [LW-1:0] LAT_MUL  = 3'd3;

  // Operation classes as seen by decode when choosing id_lat.
  typedef enum logic [1:0] {
    OP_ALU  = 2'd0,
    OP_LOAD = 2'd1,
    OP_MUL  = 2'd2
  } opClass_e;

  // Decode helper: map an operation class onto the latency the scoreboard
  // expects on id_lat.
  function automatic logic [LW-1:0] latencyOf(input opClass_e op);
    logic [LW-1:0] lat;
    lat = LAT_ALU;
    case (op)
      OP_LOAD: lat = LAT_LOAD;
      OP_MUL:  lat = LAT_MUL;
      default: lat = LAT_ALU;
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// ---------------------------------------------------------------------------
// sb_entry
//
// Purpose : State for one tracked architectural register: a busy flag that
//           stays set until writeback, and a countdown of cycles remaining
//           before a dependent instruction may issue.
//
// Ports   :
//   clk      in   pipeline clock
//   rst_n    in   asynchronous active-low reset
//   i_set    in   an instruction targeting this register issues this cycle
//   i_lat    in   latency loaded into the countdown on i_set
//   i_clear  in   writeback of this register retires this cycle
//   i_flush  in   squash all in-flight tracking
//   o_busy   out  register has an outstanding producer
//   o_cnt    out  cycles remaining before the result is forwardable
// ---------------------------------------------------------------------------
module sb_entry #(
  parameter int LW = hazard_scoreboard_pkg::LW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_set,
  input  logic [LW-1:0] i_lat,
  input  logic          i_clear,
  input  logic          i_flush,
  output logic          o_busy,
  output logic [LW-1:0] o_cnt
);

  import hazard_scoreboard_pkg::*;

  logic          r_busy;
  logic [LW-1:0] r_cnt;

  // Update priority: flush squashes everything, a new issue beats a
  // same-cycle writeback of the older producer, and otherwise the countdown
  // simply drains towards zero. busy is only dropped by writeback or flush,
  // since forwardability and retirement are separate events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_flush) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_set) begin
      r_busy <= 1'b1;
      r_cnt  <= i_lat;
    end else if (i_clear) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (r_cnt != '0) begin
      r_cnt  <= r_cnt - LW'(1);
    end
  end

  assign o_busy = r_busy;
  assign o_cnt  = r_cnt;

  // A non-zero countdown without an outstanding producer would mean the
  // priority chain above lost an update.
  a_cntImpliesBusy: assert property (
    @(posedge clk) disable iff (!rst_n) (r_cnt != '0) |-> r_busy
  );

endmodule

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Purpose : Issue-side register scoreboard. Tracks every in-flight
//           destination register from decode to writeback and stalls decode
//           while a source operand cannot yet be forwarded, or while an older
//           producer of the same destination would complete after the new one
//           (WAW ordering).
//
// Ports   :
//   clk           in   pipeline clock, all state on rising edge
//   rst_n         in   asynchronous active-low reset
//   id_valid      in   instruction present in ID
//   id_rs, id_rt  in   source registers of the ID instruction
//   id_rd         in   destination register of the ID instruction
//   id_regwrite   in   ID instruction writes id_rd
//   id_lat        in   extra cycles before the result is forwardable
//   wb_valid      in   writeback retiring a result this cycle
//   wb_rd         in   register being written back
//   flush         in   squash all in-flight tracking
//   stall         out  hold PC and IF/ID, bubble into EX
//   issue         out  id_valid & ~stall
//   busy_mask     out  per-register busy bit
//   stall_cycles  out  saturating count of stalled cycles
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int NREG     = hazard_scoreboard_pkg::NREG,
  parameter int AW       = hazard_scoreboard_pkg::AW,
  parameter int LW       = hazard_scoreboard_pkg::LW,
  parameter int NULL_REG = hazard_scoreboard_pkg::NULL_REG
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_rs,
  input  logic [AW-1:0]   id_rt,
  input  logic [AW-1:0]   id_rd,
  input  logic            id_regwrite,
  input  logic [LW-1:0]   id_lat,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic            flush,
  output logic            stall,
  output logic            issue,
  output logic [NREG-1:0] busy_mask,
  output logic [15:0]     stall_cycles
);

  import hazard_scoreboard_pkg::*;

  localparam logic [15:0]   SC_MAX   = {SC_W{1'b1}};
  localparam logic [AW-1:0] NULL_IDX = AW'(NULL_REG);

  logic [NREG-1:0] w_busy;
  logic [LW-1:0]   w_cnt [NREG];

  logic            w_rsHazard;
  logic            w_rtHazard;
  logic            w_wawHazard;
  logic            w_stall;
  logic            w_issue;

  logic [15:0]     r_stallCycles;

  // One entry per real register. The NULL_REG slot is tied off so the
  // operand muxes below can index the full array without special cases, and
  // its busy bit is structurally zero.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_entry
      if (gi == NULL_REG) begin : g_null
        assign w_busy[gi] = 1'b0;
        assign w_cnt[gi]  = '0;
      end else begin : g_live
        logic w_set;
        logic w_clr;

        assign w_set = w_issue & id_regwrite & (id_rd == AW'(gi));
        assign w_clr = wb_valid & (wb_rd == AW'(gi));

        sb_entry #(
          .LW(LW)
        ) u_entry (
          .clk     (clk),
          .rst_n   (rst_n),
          .i_set   (w_set),
          .i_lat   (id_lat),
          .i_clear (w_clr),
          .i_flush (flush),
          .o_busy  (w_busy[gi]),
          .o_cnt   (w_cnt[gi])
        );
      end
    end
  endgenerate

  // Hazard detection looks only at registered entry state, so an instruction
  // issuing this cycle never feeds back into its own stall decision. A busy
  // register whose countdown has reached zero is forwardable and does not
  // stall. WAW only matters if the older producer would finish later than
  // the new one; a writer that completes no later than the new one is fine.
  always_comb begin
    w_rsHazard  = 1'b0;
    w_rtHazard  = 1'b0;
    w_wawHazard = 1'b0;
    w_stall     = 1'b0;
    w_issue     = 1'b0;

    w_rsHazard  = (id_rs != NULL_IDX) & w_busy[id_rs] & (w_cnt[id_rs] != '0);
    w_rtHazard  = (id_rt != NULL_IDX) & w_busy[id_rt] & (w_cnt[id_rt] != '0);
    w_wawHazard = id_regwrite & (id_rd != NULL_IDX) & w_busy[id_rd] &
                  (w_cnt[id_rd] > id_lat);

    w_stall     = id_valid & (w_rsHazard | w_rtHazard | w_wawHazard);
    w_issue     = id_valid & ~w_stall;
  end

  // Performance counter of stalled cycles. It saturates rather than wraps so
  // long-running measurements never under-report, and it survives flush
  // because a flush is a normal pipeline event rather than a restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stallCycles <= '0;
    end else if (w_stall && (r_stallCycles != SC_MAX)) begin
      r_stallCycles <= r_stallCycles + 16'd1;
    end
  end

  assign stall        = w_stall;
  assign issue        = w_issue;
  assign busy_mask    = w_busy;
  assign stall_cycles = r_stallCycles;

  a_nullNeverBusy: assert property (
    @(posedge clk) disable iff (!rst_n) !w_busy[NULL_REG]
  );

  a_issueNotStalled: assert property (
    @(posedge clk) disable iff (!rst_n) !(w_issue && w_stall)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Purpose : Self-checking bench for hazard_scoreboard. The reference model
//           records, per register, whether a producer is outstanding and the
//           absolute cycle at which its result becomes forwardable; hazards
//           are derived from that ready time against the current cycle.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;

  import hazard_scoreboard_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic        id_regwrite;
  logic [2:0]  id_lat;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic        stall;
  logic        issue;
  logic [31:0] busy_mask;
  logic [15:0] stall_cycles;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state: outstanding producer flag and absolute ready cycle.
  bit     mBusy   [32];
  longint readyAt [32];
  longint cyc;
  int     mStallCnt;

  hazard_scoreboard dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rd        (id_rd),
    .id_regwrite  (id_regwrite),
    .id_lat       (id_lat),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .flush        (flush),
    .stall        (stall),
    .issue        (issue),
    .busy_mask    (busy_mask),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void mClear();
    for (int i = 0; i < 32; i++) begin
      mBusy[i]   = 1'b0;
      readyAt[i] = 0;
    end
  endfunction

  function automatic bit mHazard(input logic [4:0] s);
    return (s != 5'd31) && mBusy[s] && (readyAt[s] > cyc);
  endfunction

  function automatic bit mWaw();
    return id_regwrite && (id_rd != 5'd31) && mBusy[id_rd] &&
           ((readyAt[id_rd] - cyc) > longint'(id_lat));
  endfunction

  function automatic bit mStall();
    return id_valid && (mHazard(id_rs) || mHazard(id_rt) || mWaw());
  endfunction

  function automatic logic [31:0] mMask();
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) m[i] = mBusy[i];
    return m;
  endfunction

  function automatic int pickReg();
    int r;
    r = int'($urandom_range(0, 8));
    return (r == 8) ? 31 : r;
  endfunction

  // Drive one cycle's inputs just after the falling edge.
  task automatic applyStimulus(input bit v, input int rs, input int rt, input int rd,
                               input bit rw, input int lat, input bit wbv,
                               input int wbrd, input bit fl);
    @(negedge clk);
    id_valid    = v;
    id_rs       = 5'(rs);
    id_rt       = 5'(rt);
    id_rd       = 5'(rd);
    id_regwrite = rw;
    id_lat      = 3'(lat);
    wb_valid    = wbv;
    wb_rd       = 5'(wbrd);
    flush       = fl;
    #1;
  endtask

  // Cross the rising edge and advance the model with the inputs that were held.
  task automatic advance();
    bit st;
    bit iss;
    st  = mStall();
    iss = id_valid && !st;
    @(posedge clk);
    if (rst_n) begin
      if (st && mStallCnt < 65535) mStallCnt++;
      if (flush) begin
        mClear();
      end else begin
        if (wb_valid && wb_rd != 5'd31) begin
          mBusy[wb_rd]   = 1'b0;
          readyAt[wb_rd] = 0;
        end
        if (iss && id_regwrite && id_rd != 5'd31) begin
          mBusy[id_rd]   = 1'b1;
          readyAt[id_rd] = cyc + 1 + longint'(id_lat);
        end
      end
    end
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    id_valid = 1'b1; id_rs = 5'd3; id_rt = 5'd4; id_rd = 5'd31;
    id_regwrite = 1'b0; id_lat = 3'd0; wb_valid = 1'b0; wb_rd = 5'd31; flush = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    compared++; if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_stall: got %0b expected 0", stall); end
    compared++; if (issue !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_issue: got %0b expected 1", issue); end
    compared++; if (busy_mask !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_mask: got %h expected 0", busy_mask); end
    compared++; if (stall_cycles !== 16'h0) begin mismatched++; $display("[TB] FAIL reset_cycles: got %h expected 0", stall_cycles); end
    @(negedge clk);
    rst_n = 1'b1;
    mClear();
    mStallCnt = 0;
    cyc = 0;
    applyStimulus(1, 3, 4, 31, 0, 0, 0, 31, 0);
    compared++; if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL post_reset_stall: got %0b expected 0", stall); end
    compared++; if (issue !== 1'b1) begin mismatched++; $display("[TB] FAIL post_reset_issue: got %0b expected 1", issue); end
    advance();
  endtask

  task automatic test_load_use();
    applyStimulus(1, 0, 0, 5, 1, int'(LAT_LOAD), 0, 31, 0);
    compared++; if (issue !== 1'b1) begin mismatched++; $display("[TB] FAIL load_issue: got %0b expected 1", issue); end
    advance();
    applyStimulus(1, 5, 6, 31, 0, int'(LAT_ALU), 0, 31, 0);
    compared++; if (stall !== 1'b1) begin mismatched++; $display("[TB] FAIL load_use_stall: got %0b expected 1", stall); end
    compared++; if (busy_mask[5] !== 1'b1) begin mismatched++; $display("[TB] FAIL load_busy5: got %0b expected 1", busy_mask[5]); end
    advance();
    applyStimulus(1, 5, 6, 31, 0, int'(LAT_ALU), 0, 31, 0);
    compared++; if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL load_use_release: got %0b expected 0", stall); end
    compared++; if (issue !== 1'b1) begin mismatched++; $display("[TB] FAIL load_use_issue: got %0b expected 1", issue); end
    compared++; if (stall_cycles !== 16'd1) begin mismatched++; $display("[TB] FAIL load_cycles: got %0d expected 1", stall_cycles); end
    advance();
  endtask

  task automatic test_mul();
    applyStimulus(1, 0, 0, 7, 1, int'(LAT_MUL), 0, 31, 0);
    compared++; if (issue !== 1'b1) begin mismatched++; $display("[TB] FAIL mul_issue: got %0b expected 1", issue); end
    advance();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, 7, 31, 0, int'(LAT_ALU), 0, 31, 0);
      compared++; if (stall !== 1'b1) begin mismatched++; $display("[TB] FAIL mul_stall_%0d: got %0b expected 1", k, stall); end
      advance();
    end
    applyStimulus(1, 1, 7, 31, 0, int'(LAT_ALU), 0, 31, 0);
    compared++; if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL mul_release: got %0b expected 0", stall); end
    compared++; if (stall_cycles !== 16'd4) begin mismatched++; $display("[TB] FAIL mul_cycles: got %0d expected 4", stall_cycles); end
    advance();
    applyStimulus(1, 0, 0, 7, 1, int'(LAT_MUL), 0, 31, 0);
    advance();
    applyStimulus(1, 31, 31, 31, 1, int'(LAT_MUL), 0, 31, 0);
    compared++; if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL null_src_stall: got %0b expected 0", stall); end
    compared++; if (issue !== 1'b1) begin mismatched++; $display("[TB] FAIL null_src_issue: got %0b expected 1", issue); end
    advance();
    applyStimulus(0, 0, 0, 31, 0, 0, 0, 31, 0);
    compared++; if (busy_mask[31] !== 1'b0) begin mismatched++; $display("[TB] FAIL null_busy31: got %0b expected 0", busy_mask[31]); end
    compared++; if (busy_mask !== mMask()) begin mismatched++; $display("[TB] FAIL null_mask: got %h expected %h", busy_mask, mMask()); end
    advance();
  endtask

  task automatic test_same_cycle_wb();
    applyStimulus(1, 0, 0, 9, 1, int'(LAT_ALU), 1, 9, 0);
    compared++; if (issue !== 1'b1) begin mismatched++; $display("[TB] FAIL wb_race_issue: got %0b expected 1", issue); end
    advance();
    applyStimulus(0, 0, 0, 31, 0, 0, 1, 9, 0);
    compared++; if (busy_mask[9] !== 1'b1) begin mismatched++; $display("[TB] FAIL wb_race_busy9: got %0b expected 1", busy_mask[9]); end
    advance();
    applyStimulus(0, 0, 0, 31, 0, 0, 0, 31, 0);
    compared++; if (busy_mask[9] !== 1'b0) begin mismatched++; $display("[TB] FAIL wb_clear_busy9: got %0b expected 0", busy_mask[9]); end
    advance();
  endtask

  task automatic test_waw_flush();
    applyStimulus(1, 0, 0, 2, 1, int'(LAT_MUL), 0, 31, 0);
    advance();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, 0, 2, 1, int'(LAT_ALU), 0, 31, 0);
      compared++; if (stall !== 1'b1) begin mismatched++; $display("[TB] FAIL waw_stall_%0d: got %0b expected 1", k, stall); end
      advance();
    end
    applyStimulus(1, 0, 0, 2, 1, int'(LAT_ALU), 0, 31, 0);
    compared++; if (issue !== 1'b1) begin mismatched++; $display("[TB] FAIL waw_issue: got %0b expected 1", issue); end
    advance();
    applyStimulus(1, 0, 0, 2, 1, int'(LAT_MUL), 0, 31, 0);
    advance();
    applyStimulus(1, 0, 0, 2, 1, int'(LAT_ALU), 0, 31, 1);
    compared++; if (stall !== 1'b1) begin mismatched++; $display("[TB] FAIL flush_prestate_stall: got %0b expected 1", stall); end
    advance();
    applyStimulus(1, 0, 0, 2, 1, int'(LAT_ALU), 0, 31, 0);
    compared++; if (busy_mask !== 32'h0) begin mismatched++; $display("[TB] FAIL flush_mask: got %h expected 0", busy_mask); end
    compared++; if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_stall_drop: got %0b expected 0", stall); end
    advance();
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom_range(0, 3) != 0), pickReg(), pickReg(), pickReg(),
                    $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
                    ($urandom_range(0, 2) == 0), pickReg(),
                    ($urandom_range(0, 39) == 0));
      compared++; if (stall !== mStall()) begin mismatched++; $display("[TB] FAIL rand_stall@%0d: got %0b expected %0b", n, stall, mStall()); end
      compared++; if (issue !== (id_valid && !mStall())) begin mismatched++; $display("[TB] FAIL rand_issue@%0d: got %0b expected %0b", n, issue, id_valid && !mStall()); end
      compared++; if (busy_mask !== mMask()) begin mismatched++; $display("[TB] FAIL rand_mask@%0d: got %h expected %h", n, busy_mask, mMask()); end
      if (n % 64 == 0) begin
        compared++; if (stall_cycles !== 16'(mStallCnt)) begin mismatched++; $display("[TB] FAIL rand_cycles@%0d: got %0d expected %0d", n, stall_cycles, mStallCnt); end
      end
      advance();
    end
  endtask

  task automatic test_saturation();
    // Self-dependent writer with latency 7: seven stalled cycles per issue.
    applyStimulus(1, 2, 2, 2, 1, 7, 0, 31, 0);
    for (int n = 0; n < 76000; n++) advance();
    @(negedge clk);
    #1;
    compared++; if (stall_cycles !== 16'hFFFF) begin mismatched++; $display("[TB] FAIL sat_cycles: got %h expected ffff", stall_cycles); end
    compared++; if (stall_cycles !== 16'(mStallCnt)) begin mismatched++; $display("[TB] FAIL sat_model: got %0d expected %0d", stall_cycles, mStallCnt); end
    for (int n = 0; n < 16; n++) advance();
    @(negedge clk);
    #1;
    compared++; if (stall_cycles !== 16'hFFFF) begin mismatched++; $display("[TB] FAIL sat_hold: got %h expected ffff", stall_cycles); end
  endtask

  task automatic test_async_reset();
    bit found;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      applyStimulus(1, 2, 2, 2, 1, 7, 0, 31, 0);
      if (mStall()) found = 1'b1;
      else advance();
    end
    compared++; if (stall !== 1'b1 || !found) begin mismatched++; $display("[TB] FAIL arst_prestall: got %0b expected 1", stall); end
    #1 rst_n = 1'b0;
    #1;
    compared++; if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL arst_stall: got %0b expected 0", stall); end
    compared++; if (issue !== 1'b1) begin mismatched++; $display("[TB] FAIL arst_issue: got %0b expected 1", issue); end
    compared++; if (busy_mask !== 32'h0) begin mismatched++; $display("[TB] FAIL arst_mask: got %h expected 0", busy_mask); end
    compared++; if (stall_cycles !== 16'h0) begin mismatched++; $display("[TB] FAIL arst_cycles: got %h expected 0", stall_cycles); end
    #1 rst_n = 1'b1;
    mClear();
    mStallCnt = 0;
    advance();
    applyStimulus(1, 2, 2, 2, 1, 7, 0, 31, 0);
    compared++; if (stall !== 1'b1) begin mismatched++; $display("[TB] FAIL arst_rearm_stall: got %0b expected 1", stall); end
    compared++; if (stall_cycles !== 16'h0) begin mismatched++; $display("[TB] FAIL arst_rearm_cycles: got %0d expected 0", stall_cycles); end
    advance();
  endtask

  initial begin
    mClear();
    mStallCnt = 0;
    cyc = 0;
    test_reset();
    test_load_use();
    test_mul();
    test_same_cycle_wb();
    test_waw_flush();
    test_random();
    test_saturation();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
